// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator sequencer.
package serial_comp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic g;
      logic e;
      logic s;
   } cmp_res_t;

   localparam cmp_res_t CMP_RES_EQ = '{g: 1'b0, e: 1'b1, s: 1'b0};

   // Once g or s is set the remaining lower bits cannot change the outcome.
   function automatic logic cmp_decided(input cmp_res_t r);
      return r.g | r.s;
   endfunction

endpackage

// File: rtl/casc_comp.sv
// Cascaded one-bit magnitude compare cell: folds one bit pair into a running g/e/s state.
module casc_comp (
   input  logic i_g,
   input  logic i_e,
   input  logic i_s,
   input  logic a,
   input  logic b,
   output logic o_g,
   output logic o_e,
   output logic o_s
);

   // A decided state (g or s) passes through; only an equal state looks at the bits.
   always_comb begin
      o_g = i_g | (i_e & a & ~b);
      o_s = i_s | (i_e & ~a & b);
      o_e = i_e & ~(a ^ b);
   end

endmodule

// File: rtl/serial_comp_seq.sv
// Framed sequencer feeding WIDTH-bit operands MSB-first through one casc_comp cell.
// Optional build macro: SERIAL_COMP_SEQ_EARLY_EXIT_EN (finish as soon as the result is decided).
module serial_comp_seq
   import serial_comp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             g,
   output logic             e,
   output logic             s,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   cmp_res_t         res_q, res_d;
   logic [WIDTH-1:0] sh_a_q, sh_b_q;
   logic             load, shift;
   cmp_res_t         cell_res;

   casc_comp u_cell (
      .i_g (res_q.g),
      .i_e (res_q.e),
      .i_s (res_q.s),
      .a   (sh_a_q[WIDTH-1]),
      .b   (sh_b_q[WIDTH-1]),
      .o_g (cell_res.g),
      .o_e (cell_res.e),
      .o_s (cell_res.s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      load        = 1'b0;
      shift       = 1'b0;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               load    = 1'b1;
               res_d   = CMP_RES_EQ;
               cnt_d   = CNT_LOAD;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            res_d = cell_res;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = DONE;
            end
`ifdef SERIAL_COMP_SEQ_EARLY_EXIT_EN
            if (cmp_decided(cell_res)) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state: reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         res_q   <= CMP_RES_EQ;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Operand shifters carry data only and need no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         sh_a_q <= a;
         sh_b_q <= b;
      end else if (shift) begin
         sh_a_q <= {sh_a_q[WIDTH-2:0], 1'b0};
         sh_b_q <= {sh_b_q[WIDTH-2:0], 1'b0};
      end
   end

   assign g    = res_q.g;
   assign e    = res_q.e;
   assign s    = res_q.s;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_comp_seq.sv
// Directed bench for serial_comp_seq (WIDTH=8) with hand-computed results and latencies.
module tb_serial_comp_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_valid;
   logic       start_ready;
   logic [7:0] a, b;
   logic       res_valid;
   logic       res_ready;
   logic       g, e, s;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   serial_comp_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .g           (g),
      .e           (e),
      .s           (s),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_COMP_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
      chk({tag, "_res_valid"},   32'(res_valid),   32'd0);
      chk({tag, "_busy"},        32'(busy),        32'd0);
      chk({tag, "_ges"},         32'({g, e, s}),   32'b010);
   endtask

   // Issue one request and wait for its result; checks latency, one-hot and result.
   task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input int exp_lat, input logic [2:0] exp_ges);
      int lat;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(start_ready), 32'd1);
      a = av;
      b = bv;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = ~av;
      b = ~bv;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!res_valid && lat < 40) begin
         if (!$onehot({g, e, s})) chk({tag, "_onehot"}, 32'({g, e, s}), 32'b010);
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_ges"}, 32'({g, e, s}), 32'(exp_ges));
   endtask

   // Consumer accepts at the next edge (res_ready must already be 1).
   task automatic ack(input string tag, input logic [2:0] exp_ges);
      @(posedge clk);
      #1;
      chk({tag, "_ack_valid"}, 32'(res_valid),   32'd0);
      chk({tag, "_ack_ready"}, 32'(start_ready), 32'd1);
      chk({tag, "_ack_hold"},  32'({g, e, s}),   32'(exp_ges));
   endtask

   initial begin
      int t0, t1, n;
      rst = 1'b1;
      start_valid = 1'b0;
      a = '0;
      b = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("in_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("idle");

      // Equal operands always take the full width.
      run("eq_a5", 8'hA5, 8'hA5, 8, 3'b010);
      ack("eq_a5", 3'b010);

      // First bit differs.
      run("gt_80", 8'h80, 8'h7F, EARLY ? 1 : 8, 3'b100);
      ack("gt_80", 3'b100);

      // Last bit differs; result held while the consumer stalls.
      res_ready = 1'b0;
      run("lt_12", 8'h12, 8'h13, 8, 3'b001);
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'b1;
         a = 8'hFF;
         b = 8'h00;
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(res_valid),   32'd1);
         chk("hold_ges",   32'({g, e, s}),   32'b001);
         chk("hold_ready", 32'(start_ready), 32'd0);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      ack("lt_12", 3'b001);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      a = 8'hFF;
      b = 8'h00;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_vals("abort");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run("after_rst", 8'h01, 8'h02, EARLY ? 7 : 8, 3'b001);
      ack("after_rst", 3'b001);

      // Back-to-back with start_valid held high.
      @(negedge clk);
      a = 8'h00;
      b = 8'hFF;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      n = 0;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_ges", 32'({g, e, s}), 32'b001);
      a = 8'hFF;
      b = 8'h00;
      n = 0;
      t1 = -1;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (start_ready) begin
            @(posedge clk);
            #1;
            t1 = cyc;
            break;
         end
      end
      chk("b2b_period", 32'(t1 - t0), EARLY ? 32'd3 : 32'd10);
      start_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_second_ges", 32'({g, e, s}), 32'b100);
      ack("b2b_second", 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: sim time exceeded, expected completion");
      $fatal(1, "timeout");
   end

endmodule
